// File: rtl/sccb_pkg.sv
// sccb_pkg: FSM state encoding and bus constants shared by the SCCB target files
package sccb_pkg;
    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE
    } state_t;
    localparam logic [6:0] DEF_DEV_ADDR = 7'h30;
    localparam int         MIN_SYNC     = 2;
    localparam logic       BUS_IDLE     = 1'b1;
endpackage

// File: rtl/sccb_target_if.sv
// sccb_target_if: SCCB pins plus the register-file strobe/read port of the target
interface sccb_target_if;
    logic       scl_in, sda_in, sda_oe, wr_en, busy;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    modport slave (input scl_in, sda_in, rd_data, output sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy);
    modport master (output scl_in, sda_in, rd_data, input sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy);
endinterface

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: synchronizes SCL/SDA and flags SCL edges, START and STOP
module sccb_line_sync
    import sccb_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda
);
    localparam int N = SYNC_STAGES < MIN_SYNC ? MIN_SYNC : SYNC_STAGES;
    // bit N holds the previous synchronized sample for edge detection
    logic [N:0] scl_r, sda_r;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_r <= {(N+1){BUS_IDLE}};
            sda_r <= {(N+1){BUS_IDLE}};
        end else begin
            scl_r <= {scl_r[N-1:0], scl_in};
            sda_r <= {sda_r[N-1:0], sda_in};
        end
    end
    assign sda      = sda_r[N-1];
    assign scl_rise = scl_r[N-1] & ~scl_r[N];
    assign scl_fall = ~scl_r[N-1] & scl_r[N];
    assign start    = scl_r[N-1] & scl_r[N] & sda_r[N] & ~sda_r[N-1];
    assign stop     = scl_r[N-1] & scl_r[N] & ~sda_r[N] & sda_r[N-1];
endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB responder turning OV2640-addressed bus transfers into register-file strobes
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
    parameter bit         AUTO_INC    = 1'b1,
    parameter int         SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          reset_n,
    sccb_target_if.slave bus
);
    logic       scl_rise, scl_fall, start, stop, sda;
    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shift, shift_n, ptr, ptr_n, wr_addr, wr_addr_n, wr_data, wr_data_n, rx_byte;
    logic       sda_oe, sda_oe_n, wr_en, wr_en_n, busy, busy_n;

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .reset_n(reset_n), .scl_in(bus.scl_in), .sda_in(bus.sda_in),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop), .sda(sda)
    );

    assign rx_byte     = {shift[6:0], sda};
    assign bus.sda_oe  = sda_oe;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign bus.rd_addr = ptr;
    assign bus.busy    = busy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            shift   <= '0;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shift   <= shift_n;
            ptr     <= ptr_n;
            sda_oe  <= sda_oe_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            busy    <= busy_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shift_n   = shift;
        ptr_n     = (wr_en && AUTO_INC) ? ptr + 8'd1 : ptr;
        sda_oe_n  = sda_oe;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        busy_n    = busy;
        if (start) begin
            state_n  = DEV;
            cnt_n    = '0;
            busy_n   = 1'b1;
            sda_oe_n = 1'b0;
        end else if (stop) begin
            state_n  = IDLE;
            cnt_n    = '0;
            busy_n   = 1'b0;
            sda_oe_n = 1'b0;
        end else begin
            case (state)
                DEV, REG, WDATA: if (scl_rise) begin
                    shift_n = rx_byte;
                    cnt_n   = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_n   = '0;
                        state_n = (state == DEV) ? ((rx_byte[7:1] == DEV_ADDR) ? DEV_ACK : IGNORE)
                                                 : ((state == REG) ? REG_ACK : WDATA_ACK);
                        if (state == REG) ptr_n = rx_byte;
                    end
                end
                // first fall after the byte drives ACK, the second releases it and moves on
                DEV_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
                    sda_oe_n = ~sda_oe;
                    if (!sda_oe && state == WDATA_ACK) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = ptr;
                        wr_data_n = shift;
                    end
                    if (sda_oe) begin
                        state_n = (state != DEV_ACK) ? WDATA : (shift[0] ? RDATA : REG);
                        if (state == DEV_ACK && shift[0]) begin
                            shift_n  = bus.rd_data;
                            sda_oe_n = ~bus.rd_data[7];
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) cnt_n = cnt + 4'd1;
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_oe_n = 1'b0;
                            cnt_n    = '0;
                            state_n  = RD_MACK;
                        end else begin
                            shift_n  = {shift[6:0], 1'b0};
                            sda_oe_n = ~shift[6];
                        end
                    end
                end
                // cnt==1 marks a received master ACK awaiting the reload fall
                RD_MACK: begin
                    if (scl_rise) begin
                        if (sda) state_n = IGNORE;
                        else begin
                            cnt_n = 4'd1;
                            if (AUTO_INC) ptr_n = ptr + 8'd1;
                        end
                    end
                    if (scl_fall && cnt == 4'd1) begin
                        shift_n  = bus.rd_data;
                        sda_oe_n = ~bus.rd_data[7];
                        cnt_n    = '0;
                        state_n  = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: randomized SCCB master driving sccb_target against a register-file reference model
module tb_sccb_target;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    sccb_target_if bus ();
    sccb_target #(.DEV_ADDR(7'h30), .AUTO_INC(1'b1), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    logic [7:0] regs [256] = '{default: 8'h00};
    assign bus.scl_in  = scl_m;
    assign bus.sda_in  = sda_m & ~bus.sda_oe;
    assign bus.rd_data = regs[bus.rd_addr];
    always #5 clk = ~clk;
    always @(posedge clk) if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t        exp_wr [$];
    logic [7:0] mreg [256] = '{default: 8'h00};
    logic [7:0] mptr = 8'h00;
    logic       quiet = 1'b0;
    int         quiet_hits = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic q();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; q(); scl_m = 1'b1; q(); q(); scl_m = 1'b0; q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; q(); scl_m = 1'b1; q(); b = bus.sda_in; q(); scl_m = 1'b0; q();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q(); q();
    endtask

    task automatic put_byte(input logic [7:0] b, input logic ack, input string name);
        logic x;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        read_bit(x);
        check(name, 32'(!x), 32'(ack));
    endtask

    task automatic get_byte(input logic nack, output logic [7:0] b);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            read_bit(x);
            b[i] = x;
        end
        send_bit(nack);
    endtask

    task automatic do_write(input logic [7:0] dev, input logic [7:0] ra, input logic [7:0] d [3], input int n);
        logic ok;
        ok = (dev == 8'h60);
        quiet = !ok;
        quiet_hits = 0;
        i2c_start();
        check("busy_start", 32'(bus.busy), 1);
        put_byte(dev, ok, "ack_dev");
        if (ok) mptr = ra;
        put_byte(ra, ok, "ack_reg");
        for (int k = 0; k < n; k++) begin
            if (ok) begin
                exp_wr.push_back(wr_t'({mptr, d[k]}));
                mreg[mptr] = d[k];
                mptr++;
            end
            put_byte(d[k], ok, "ack_wdata");
        end
        i2c_stop();
        check("busy_stop", 32'(bus.busy), 0);
        if (!ok) check("quiet_oe", 32'(quiet_hits), 0);
        quiet = 1'b0;
        check("rd_addr_wr", 32'(bus.rd_addr), 32'(mptr));
    endtask

    task automatic do_read(input logic [7:0] ra, input int n);
        logic [7:0] b;
        logic [7:0] nod [3];
        nod = '{default: 8'h00};
        do_write(8'h60, ra, nod, 0);
        i2c_start();
        put_byte(8'h61, 1'b1, "ack_rdev");
        for (int k = 0; k < n; k++) begin
            get_byte(k == n - 1, b);
            check("rd_byte", 32'(b), 32'(mreg[mptr]));
            if (k != n - 1) mptr++;
        end
        i2c_stop();
        check("busy_rd_stop", 32'(bus.busy), 0);
        check("rd_addr_rd", 32'(bus.rd_addr), 32'(mptr));
    endtask

    task automatic mon_wr();
        logic prev;
        wr_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wr_en) begin
                check("wr_en_pulse", 32'(prev), 0);
                if (exp_wr.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got wr_addr 0x%0h wr_data 0x%0h, required no write", bus.wr_addr, bus.wr_data);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(bus.wr_addr), 32'(e.a));
                    check("wr_data", 32'(bus.wr_data), 32'(e.d));
                end
            end
            prev = bus.wr_en;
        end
    endtask

    task automatic mon_quiet();
        forever begin
            @(negedge clk);
            if (quiet && bus.sda_oe) quiet_hits++;
        end
    endtask

    task automatic rand_phase();
        logic [7:0] d [3];
        logic [7:0] ra, dev;
        int n, kind;
        for (int t = 0; t < 20; t++) begin
            kind = int'($urandom_range(0, 3));
            ra   = 8'($urandom);
            n    = int'($urandom_range(1, 3));
            foreach (d[k]) d[k] = 8'($urandom);
            dev  = 8'($urandom) & 8'hFE;
            if (dev == 8'h60) dev = 8'h62;
            if (kind == 0) do_write(dev, ra, d, n);
            else if (kind == 1) do_read(ra, n);
            else do_write(8'h60, ra, d, n);
        end
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got no end of test within 95000 cycles, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic x;
        logic [7:0] b;
        fork
            mon_wr();
            mon_quiet();
        join_none
        repeat (4) @(posedge clk);
        #1;
        check("rst_sda_oe", 32'(bus.sda_oe), 0);
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_wr_data", 32'(bus.wr_data), 0);
        check("rst_rd_addr", 32'(bus.rd_addr), 0);
        check("rst_busy", 32'(bus.busy), 0);
        reset_n = 1'b1;
        q();
        do_write(8'h60, 8'h12, '{8'h80, 8'h00, 8'h00}, 1);
        do_write(8'h42, 8'h12, '{8'h80, 8'h00, 8'h00}, 1);
        do_write(8'h60, 8'h0A, '{8'h26, 8'h00, 8'h00}, 1);
        do_read(8'h0A, 1);
        do_write(8'h60, 8'hFF, '{8'h11, 8'h22, 8'h00}, 2);
        do_read(8'hFF, 2);
        // repeated START cuts a data byte after four bits
        i2c_start();
        put_byte(8'h60, 1'b1, "ack_dev_rs");
        put_byte(8'h33, 1'b1, "ack_reg_rs");
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        i2c_start();
        put_byte(8'h60, 1'b1, "ack_dev_rs2");
        put_byte(8'h05, 1'b1, "ack_reg_rs2");
        mptr = 8'h05;
        exp_wr.push_back(wr_t'({8'h05, 8'h07}));
        mreg[8'h05] = 8'h07;
        mptr++;
        put_byte(8'h07, 1'b1, "ack_wdata_rs2");
        i2c_stop();
        check("rd_addr_rs", 32'(bus.rd_addr), 32'(mptr));
        // reset while the target pulls SDA for a zero data bit
        do_write(8'h60, 8'h40, '{8'h00, 8'h00, 8'h00}, 1);
        do_write(8'h60, 8'h40, '{8'h00, 8'h00, 8'h00}, 0);
        i2c_start();
        put_byte(8'h61, 1'b1, "ack_rdev_rst");
        check("oe_before_reset", 32'(bus.sda_oe), 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_sda_oe", 32'(bus.sda_oe), 0);
        check("rst_mid_rd_addr", 32'(bus.rd_addr), 0);
        check("rst_mid_busy", 32'(bus.busy), 0);
        reset_n = 1'b1;
        mptr = 8'h00;
        i2c_stop();
        do_write(8'h60, 8'h07, '{8'h5A, 8'h00, 8'h00}, 1);
        do_read(8'h07, 1);
        rand_phase();
        q();
        check("wr_pending", 32'(exp_wr.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
